// File: rtl/lock_input_arbiter.sv
// Button front end for the digital lock: sync, debounce, edge-to-event, fixed-priority arbiter, valid/ready delivery.
// Optional failed-attempt lockout enabled by defining LOCK_ARB_LOCKOUT_EN.
module lock_input_arbiter #(
  parameter int DEB_CYCLES     = 20,
  parameter int CNT_W          = 20,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ent,
  input  logic       btn_clr,
  input  logic       btn_chg,
  input  logic       ev_ready,
  input  logic       fail,
  input  logic       pass,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  output logic       locked_out,
  output logic [2:0] fail_cnt
);

  // Bit order in every 3-bit button vector: [0]=ENT, [1]=CLR, [2]=CHG.
  localparam logic [2:0]       B_ALL    = 3'b111;
  localparam logic [2:0]       B_CLR    = 3'b010;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       deb;
  logic [2:0]       pend;
  logic [2:0]       rise;
  logic [2:0]       grant;
  logic [2:0]       keep;
  logic [2:0]       eff;
  logic [CNT_W-1:0] deb_cnt [3];
  logic             locked;
  state_t           state;

  assign raw = {btn_chg, btn_clr, btn_ent};

  function automatic logic [1:0] code_of(input logic [2:0] g);
    logic [1:0] c;
    case (g)
      3'b001:  c = 2'b01;
      3'b010:  c = 2'b10;
      3'b100:  c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= ~deb[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // A rise is the cycle in which a low debounced level is about to flip high.
  always_comb begin
    rise = 3'b000;
    for (int i = 0; i < 3; i++) begin
      rise[i] = sync2[i] & ~deb[i] & (deb_cnt[i] == DEB_LAST);
    end
  end

  assign keep = locked ? B_CLR : B_ALL;
  assign eff  = pend & keep;

  always_comb begin
    grant = 3'b000;
    if (state == IDLE) begin
      if (eff[1])      grant = 3'b010;
      else if (eff[2]) grant = 3'b100;
      else if (eff[0]) grant = 3'b001;
      else             grant = 3'b000;
    end else begin
      grant = 3'b000;
    end
  end

  // Edges on an already-pending button are dropped; lockout masks ENT/CHG.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= 3'b000;
    else     pend <= (pend & ~grant & keep) | (rise & keep & ~pend);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ev_valid <= 1'b0;
      ev_code  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            state    <= OFFER;
            ev_valid <= 1'b1;
            ev_code  <= code_of(grant);
          end
        end
        OFFER: begin
          if (ev_ready) begin
            state    <= IDLE;
            ev_valid <= 1'b0;
            ev_code  <= 2'b00;
          end
        end
        default: begin
          state    <= IDLE;
          ev_valid <= 1'b0;
          ev_code  <= 2'b00;
        end
      endcase
    end
  end

`ifdef LOCK_ARB_LOCKOUT_EN
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]       FAIL_MAX  = 3'(MAX_FAILS);

  logic [CNT_W-1:0] lock_timer;

  // fail/pass are ignored while locked and in the cycle the lockout is being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked     <= 1'b0;
      fail_cnt   <= 3'd0;
      lock_timer <= '0;
    end else if (locked) begin
      if (lock_timer == LOCK_LAST) begin
        locked     <= 1'b0;
        fail_cnt   <= 3'd0;
        lock_timer <= '0;
      end else begin
        lock_timer <= lock_timer + 1'b1;
      end
    end else if (fail_cnt == FAIL_MAX) begin
      locked     <= 1'b1;
      lock_timer <= '0;
    end else if (pass) begin
      fail_cnt <= 3'd0;
    end else if (fail) begin
      fail_cnt <= fail_cnt + 3'd1;
    end
  end
`else
  logic unused_lockout;
  assign unused_lockout = ^{fail, pass, MAX_FAILS[0], LOCKOUT_CYCLES[0]};
  assign locked   = 1'b0;
  assign fail_cnt = 3'd0;
`endif

  assign locked_out = locked;

endmodule

// File: tb/tb_lock_input_arbiter.sv
// Self-checking bench for lock_input_arbiter: directed scenarios plus a randomized run against a
// cycle-level reference model built from the button/event rules; works with or without LOCK_ARB_LOCKOUT_EN.
module tb_lock_input_arbiter;

  localparam int DEB  = 20;
  localparam int LOCK = 50;
  localparam int MAXF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_ent = 1'b0, btn_clr = 1'b0, btn_chg = 1'b0;
  logic       ev_ready = 1'b0, fail = 1'b0, pass = 1'b0;
  logic       ev_valid, locked_out;
  logic [1:0] ev_code;
  logic [2:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  lock_input_arbiter #(.DEB_CYCLES(DEB), .CNT_W(20), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK)) dut (
    .clk(clk), .rst(rst), .btn_ent(btn_ent), .btn_clr(btn_clr), .btn_chg(btn_chg),
    .ev_ready(ev_ready), .fail(fail), .pass(pass), .ev_valid(ev_valid), .ev_code(ev_code),
    .locked_out(locked_out), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

`ifdef LOCK_ARB_LOCKOUT_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  // Reference model state; index 0=ENT, 1=CLR, 2=CHG.
  bit       m_s1 [3], m_s2 [3], m_deb [3], m_pend [3];
  int       m_run [3];
  bit       m_valid, m_locked;
  bit [1:0] m_code;
  int       m_fcnt, m_timer;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_pend[i] = 0; m_run[i] = 0;
    end
    m_valid = 0; m_code = 2'b00; m_locked = 0; m_fcnt = 0; m_timer = 0;
  endtask

  task automatic model_step();
    bit raw [3];
    bit rise [3];
    bit pend_old [3];
    int sel;
    raw[0] = btn_ent; raw[1] = btn_clr; raw[2] = btn_chg;
    for (int i = 0; i < 3; i++) begin
      rise[i] = 0;
      pend_old[i] = m_pend[i];
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_deb[i] = !m_deb[i];
          m_run[i] = 0;
          rise[i]  = m_deb[i];
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
    sel = -1;
    if (!m_valid) begin
      if (m_pend[1]) sel = 1;
      else if (!m_locked && m_pend[2]) sel = 2;
      else if (!m_locked && m_pend[0]) sel = 0;
    end else if (ev_ready) begin
      m_valid = 0;
      m_code  = 2'b00;
    end
    if (sel >= 0) begin
      m_pend[sel] = 0;
      m_valid = 1;
      m_code  = (sel == 1) ? 2'b10 : (sel == 2) ? 2'b11 : 2'b01;
    end
    for (int i = 0; i < 3; i++) begin
      if (m_locked && i != 1) m_pend[i] = 0;
      else if (rise[i] && !pend_old[i]) m_pend[i] = 1;
    end
    if (LOCK_ON) begin
      if (m_locked) begin
        m_timer++;
        if (m_timer == LOCK) begin m_locked = 0; m_fcnt = 0; m_timer = 0; end
      end else if (m_fcnt == MAXF) begin
        m_locked = 1; m_timer = 0;
      end else if (pass) begin
        m_fcnt = 0;
      end else if (fail) begin
        m_fcnt++;
      end
    end
  endtask

  // One clock: the model advances on the active edge, outputs are then sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    btn_ent = 0; btn_clr = 0; btn_chg = 0; ev_ready = 0; fail = 0; pass = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ev_valid !== 1'b0 || ev_code !== 2'b00 || locked_out !== 1'b0 || fail_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset: got v=%b c=%b l=%b f=%0d want 0 00 0 0", ev_valid, ev_code, locked_out, fail_cnt);
    end
    apply_reset();
  endtask

  task automatic test_bounce();
    int pulses = 0;
    logic [1:0] pcode = 2'b00;
    logic prev = 1'b0;
    apply_reset();
    ev_ready = 1;
    for (int c = 0; c < 95; c++) begin
      if (c < 15) btn_ent = ((c / 3) % 2 == 0);
      else if (c < 55) btn_ent = 1;
      else btn_ent = 0;
      step();
      if (ev_valid && !prev) begin pulses++; pcode = ev_code; end
      prev = ev_valid;
    end
    checks++;
    if (pulses !== 1 || pcode !== 2'b01) begin
      errors++;
      $display("FAIL bounce: got pulses=%0d code=%b want pulses=1 code=01", pulses, pcode);
    end
  endtask

  task automatic test_priority();
    logic [1:0] codes [$];
    int starts [$];
    logic prev = 1'b0;
    apply_reset();
    ev_ready = 1;
    btn_ent = 1; btn_clr = 1;
    for (int c = 0; c < 60; c++) begin
      step();
      if (ev_valid && !prev) begin codes.push_back(ev_code); starts.push_back(c); end
      prev = ev_valid;
    end
    btn_ent = 0; btn_clr = 0;
    checks++;
    if (codes.size() != 2) begin
      errors++;
      $display("FAIL priority_count: got %0d events want 2", codes.size());
    end else begin
      checks++;
      if (codes[0] !== 2'b10 || codes[1] !== 2'b01 || starts[1] - starts[0] != 2) begin
        errors++;
        $display("FAIL priority_order: got %b,%b gap=%0d want 10,01 gap=2", codes[0], codes[1], starts[1] - starts[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [1:0] nxt = 2'b00;
    apply_reset();
    ev_ready = 0;
    btn_ent = 1;
    n = 0;
    while (!ev_valid && n < 60) begin step(); n++; end
    checks++;
    if (!ev_valid || ev_code !== 2'b01) begin
      errors++;
      $display("FAIL bp_first: got v=%b c=%b want v=1 c=01", ev_valid, ev_code);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== 2'b01) begin
        errors++;
        $display("FAIL bp_hold cyc %0d: got v=%b c=%b want v=1 c=01", c, ev_valid, ev_code);
      end
    end
    btn_chg = 1; ev_ready = 1;
    step();
    n = 0;
    while (!ev_valid && n < 60) begin step(); n++; end
    nxt = ev_code;
    checks++;
    if (!ev_valid || nxt !== 2'b11) begin
      errors++;
      $display("FAIL bp_next: got v=%b c=%b want v=1 c=11", ev_valid, nxt);
    end
    btn_ent = 0; btn_chg = 0;
  endtask

  task automatic test_reset_mid_offer();
    int n;
    int seen = 0;
    apply_reset();
    ev_ready = 0;
    btn_ent = 1;
    n = 0;
    while (!ev_valid && n < 60) begin step(); n++; end
    btn_clr = 1;
    repeat (30) step();
    checks++;
    if (ev_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got v=%b want 1", ev_valid);
    end
    #2;
    rst = 1'b1; btn_ent = 0; btn_clr = 0;
    #1;
    checks++;
    if (ev_valid !== 1'b0 || ev_code !== 2'b00) begin
      errors++;
      $display("FAIL rst_async: got v=%b c=%b want v=0 c=00", ev_valid, ev_code);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ev_ready = 1;
    for (int c = 0; c < 50; c++) begin
      step();
      if (ev_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_after: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_lockout();
    logic [1:0] codes [$];
    logic prev = 1'b0;
    bit exp_l = LOCK_ON;
    int exp_f = LOCK_ON ? 3 : 0;
    int exp_n = LOCK_ON ? 1 : 2;
    apply_reset();
    ev_ready = 1;
    for (int k = 0; k < 3; k++) begin
      fail = 1; step(); fail = 0;
      if (k < 2) step();
    end
    checks++;
    if (fail_cnt !== 3'(exp_f) || locked_out !== 1'b0) begin
      errors++;
      $display("FAIL lock_cnt: got f=%0d l=%b want f=%0d l=0", fail_cnt, locked_out, exp_f);
    end
    step();
    checks++;
    if (locked_out !== exp_l) begin
      errors++;
      $display("FAIL lock_enter: got l=%b want %b", locked_out, exp_l);
    end
    btn_ent = 1; btn_clr = 1;
    for (int c = 0; c < LOCK - 1; c++) begin
      if (c == 35) begin btn_ent = 0; btn_clr = 0; end
      step();
      if (ev_valid && !prev) codes.push_back(ev_code);
      prev = ev_valid;
    end
    checks++;
    if (locked_out !== exp_l) begin
      errors++;
      $display("FAIL lock_hold: got l=%b want %b", locked_out, exp_l);
    end
    checks++;
    if (codes.size() != exp_n || codes[0] !== 2'b10) begin
      errors++;
      $display("FAIL lock_events: got %0d events first=%b want %0d first=10", codes.size(),
               (codes.size() > 0) ? codes[0] : 2'b00, exp_n);
    end
    step();
    checks++;
    if (locked_out !== 1'b0 || fail_cnt !== 3'd0) begin
      errors++;
      $display("FAIL lock_exit: got l=%b f=%0d want l=0 f=0", locked_out, fail_cnt);
    end
  endtask

  task automatic test_fail_pass();
    int exp_f = LOCK_ON ? 1 : 0;
    apply_reset();
    fail = 1; step(); fail = 0; step();
    fail = 1; step(); fail = 0; step();
    pass = 1; step(); pass = 0; step();
    fail = 1; step(); fail = 0;
    repeat (3) step();
    checks++;
    if (fail_cnt !== 3'(exp_f) || locked_out !== 1'b0) begin
      errors++;
      $display("FAIL fail_pass: got f=%0d l=%b want f=%0d l=0", fail_cnt, locked_out, exp_f);
    end
  endtask

  task automatic test_random();
    int hold [3];
    apply_reset();
    for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 40);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 3; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(20, 60);
          if (i == 0) btn_ent = ~btn_ent;
          else if (i == 1) btn_clr = ~btn_clr;
          else btn_chg = ~btn_chg;
        end
      end
      ev_ready = ($urandom_range(0, 3) != 0);
      fail = ($urandom_range(0, 19) == 0);
      pass = !fail && ($urandom_range(0, 59) == 0);
      step();
      checks++;
      if (ev_valid !== m_valid || ev_code !== m_code || locked_out !== m_locked || fail_cnt !== 3'(m_fcnt)) begin
        errors++;
        $display("FAIL random cyc %0d: got v=%b c=%b l=%b f=%0d want v=%b c=%b l=%b f=%0d", c,
                 ev_valid, ev_code, locked_out, fail_cnt, m_valid, m_code, m_locked, m_fcnt);
      end
    end
    fail = 0; pass = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bounce();
    test_priority();
    test_backpressure();
    test_reset_mid_offer();
    test_lockout();
    test_fail_pass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
